// File: rtl/aq_jpeg_fdct_calc.sv
// aq_jpeg_fdct_calc: 8-point 1-D forward DCT, sample pairs in, Q12 coefficient pairs out.
// Optional macro AQ_FDCT_ROUND_EN: round each coefficient to an integer, (X + 2048) >>> 12.
module aq_jpeg_fdct_calc (
    input  logic               clk,
    input  logic               rst,
    input  logic               DataInEnable,
    output logic               DataInRead,
    output logic [4:0]         DataInAddress,
    input  logic signed [15:0] DataInA,
    input  logic signed [15:0] DataInB,
    output logic               DataOutEnable,
    output logic [2:0]         DataOutPage,
    output logic [1:0]         DataOutCount,
    output logic signed [31:0] Data0Out,
    output logic signed [31:0] Data1Out
);
    localparam logic signed [31:0] C1 = 32'sd4017;
    localparam logic signed [31:0] C2 = 32'sd3784;
    localparam logic signed [31:0] C3 = 32'sd3406;
    localparam logic signed [31:0] C4 = 32'sd2896;
    localparam logic signed [31:0] C5 = 32'sd2276;
    localparam logic signed [31:0] C6 = 32'sd1567;
    localparam logic signed [31:0] C7 = 32'sd799;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         p_q, p_d, c_q, c_d;
    logic               rd_q;
    logic [1:0]         ridx_q;
    logic [2:0]         rpage_q;
    logic signed [16:0] s_q [0:2];
    logic signed [16:0] d_q [0:2];
    logic signed [31:0] ss_q [0:3];
    logic signed [31:0] sd_q [0:3];
    logic               act_q;
    logic [1:0]         k_q;
    logic [2:0]         opage_q;
    logic               oe_q;
    logic [2:0]         pg_q;
    logic [1:0]         cnt_q;
    logic signed [31:0] o0_q, o1_q;
    logic signed [16:0] s_in, d_in;
    logic signed [31:0] x0, x1, x2, x3, x4, x5, x6, x7, y0, y1;

    function automatic logic signed [31:0] fmt(input logic signed [31:0] x);
`ifdef AQ_FDCT_ROUND_EN
        return (x + 32'sd2048) >>> 12;
`else
        return x;
`endif
    endfunction

    assign DataInRead    = (state_q == RUN) && !c_q[2];
    assign DataInAddress = {p_q, c_q[1:0]};
    assign s_in          = 17'(DataInA) + 17'(DataInB);
    assign d_in          = 17'(DataInA) - 17'(DataInB);
    assign DataOutEnable = oe_q;
    assign DataOutPage   = pg_q;
    assign DataOutCount  = cnt_q;
    assign Data0Out      = o0_q;
    assign Data1Out      = o1_q;

    // Sequencer next state: wait for a start, then sweep 8 pages of 8 slots.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        c_d     = c_q;
        if (state_q == IDLE) begin
            state_d = DataInEnable ? RUN : IDLE;
            p_d     = 3'd0;
            c_d     = 3'd0;
        end else begin
            c_d     = c_q + 3'd1;
            p_d     = (c_q == 3'd7) ? p_q + 3'd1 : p_q;
            state_d = (p_q == 3'd7 && c_q == 3'd7) ? IDLE : RUN;
        end
    end

    // Sequencer state and page/slot counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= 3'd0;
            c_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            c_q     <= c_d;
        end
    end

    // Butterfly capture per pair; the row is frozen on its last pair so the next row can refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= 1'b0;
            ridx_q  <= 2'd0;
            rpage_q <= 3'd0;
            act_q   <= 1'b0;
            k_q     <= 2'd0;
            opage_q <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                s_q[i] <= '0;
                d_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                ss_q[i] <= '0;
                sd_q[i] <= '0;
            end
        end else begin
            rd_q    <= DataInRead;
            ridx_q  <= c_q[1:0];
            rpage_q <= p_q;
            for (int i = 0; i < 3; i++) begin
                s_q[i] <= (rd_q && ridx_q == 2'(i)) ? s_in : s_q[i];
                d_q[i] <= (rd_q && ridx_q == 2'(i)) ? d_in : d_q[i];
            end
            if (rd_q && ridx_q == 2'd3) begin
                for (int i = 0; i < 3; i++) begin
                    ss_q[i] <= 32'(s_q[i]);
                    sd_q[i] <= 32'(d_q[i]);
                end
                ss_q[3] <= 32'(s_in);
                sd_q[3] <= 32'(d_in);
                act_q   <= 1'b1;
                k_q     <= 2'd0;
                opage_q <= rpage_q;
            end else if (act_q) begin
                k_q   <= k_q + 2'd1;
                act_q <= (k_q != 2'd3);
            end
        end
    end

    // Even/odd coefficient equations and selection of the pair for the current output slot.
    always_comb begin
        x0 = (ss_q[0] + ss_q[1] + ss_q[2] + ss_q[3]) * C4;
        x4 = (ss_q[0] - ss_q[1] - ss_q[2] + ss_q[3]) * C4;
        x2 = (ss_q[0] - ss_q[3]) * C2 + (ss_q[1] - ss_q[2]) * C6;
        x6 = (ss_q[0] - ss_q[3]) * C6 - (ss_q[1] - ss_q[2]) * C2;
        x1 = sd_q[0] * C1 + sd_q[1] * C3 + sd_q[2] * C5 + sd_q[3] * C7;
        x3 = sd_q[0] * C3 - sd_q[1] * C7 - sd_q[2] * C1 - sd_q[3] * C5;
        x5 = sd_q[0] * C5 - sd_q[1] * C1 + sd_q[2] * C7 + sd_q[3] * C3;
        x7 = sd_q[0] * C7 - sd_q[1] * C5 + sd_q[2] * C3 - sd_q[3] * C1;
        y0 = (k_q == 2'd0) ? x0 : (k_q == 2'd1) ? x2 : (k_q == 2'd2) ? x1 : x3;
        y1 = (k_q == 2'd0) ? x4 : (k_q == 2'd1) ? x6 : (k_q == 2'd2) ? x7 : x5;
    end

    // Output register: coefficient pair plus its row and slot tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oe_q  <= 1'b0;
            pg_q  <= 3'd0;
            cnt_q <= 2'd0;
            o0_q  <= '0;
            o1_q  <= '0;
        end else begin
            oe_q  <= act_q;
            pg_q  <= opage_q;
            cnt_q <= k_q;
            o0_q  <= fmt(y0);
            o1_q  <= fmt(y1);
        end
    end
endmodule

// File: tb/tb_aq_jpeg_fdct_calc.sv
// tb_aq_jpeg_fdct_calc: directed-vector bench for the 1-D FDCT engine with a row-buffer model.
module tb_aq_jpeg_fdct_calc;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               DataInEnable = 1'b0;
    logic               DataInRead;
    logic [4:0]         DataInAddress;
    logic signed [15:0] DataInA = '0;
    logic signed [15:0] DataInB = '0;
    logic               DataOutEnable;
    logic [2:0]         DataOutPage;
    logic [1:0]         DataOutCount;
    logic signed [31:0] Data0Out, Data1Out;

    int     vec = 0;
    int     bad = 0;
    int     mem [2][64];
    longint e0 [2][8][4];
    longint e1 [2][8][4];
    int     bank = 0;
    logic   rd_s = 1'b0;
    logic [4:0] ad_s = '0;

`ifdef AQ_FDCT_ROUND_EN
    longint hand [4][8] = '{'{566, 0, 0, 0, 0, 0, 0, 0},
                            '{707, 707, 924, 383, 981, 195, 832, 556},
                            '{-6, 0, 0, 0, 0, 0, 0, 0},
                            '{-3, 0, 0, 0, 167965, -33407, -58975, 39423}};
`else
    longint hand [4][8] = '{'{2316800, 0, 0, 0, 0, 0, 0, 0},
                            '{2896000, 2896000, 3784000, 1567000, 4017000, 799000, 3406000, 2276000},
                            '{-23168, 0, 0, 0, 0, 0, 0, 0},
                            '{-11584, 0, 0, 0, 687986430, -136837080, -241562010, 161478240}};
`endif

    aq_jpeg_fdct_calc dut (
        .clk(clk), .rst(rst), .DataInEnable(DataInEnable), .DataInRead(DataInRead),
        .DataInAddress(DataInAddress), .DataInA(DataInA), .DataInB(DataInB),
        .DataOutEnable(DataOutEnable), .DataOutPage(DataOutPage), .DataOutCount(DataOutCount),
        .Data0Out(Data0Out), .Data1Out(Data1Out)
    );

    always #5 clk = ~clk;

    // Row buffer: answers a read one cycle later with x[idx] and x[7-idx].
    always @(negedge clk) begin
        rd_s = DataInRead;
        ad_s = DataInAddress;
    end
    always @(posedge clk) begin
        #1;
        if (rd_s) begin
            DataInA = 16'(mem[bank][int'(ad_s[4:2]) * 8 + int'(ad_s[1:0])]);
            DataInB = 16'(mem[bank][int'(ad_s[4:2]) * 8 + 7 - int'(ad_s[1:0])]);
        end
    end

    task automatic load(input int b, input int pat);
        longint x [8];
        longint s [4];
        longint d [4];
        longint X [8];
        for (int pg = 0; pg < 8; pg++) begin
            for (int n = 0; n < 8; n++) begin
                x[n] = pat == 0 ? 64'sd100 : pat == 1 ? (n == 0 ? 64'sd1000 : 64'sd0) : pat == 2 ? -64'sd1 :
                       pat == 3 ? (n < 4 ? 64'sd32767 : -64'sd32768) : longint'($urandom_range(65535)) - 64'sd32768;
                mem[b][pg * 8 + n] = int'(x[n]);
            end
            for (int i = 0; i < 4; i++) begin
                s[i] = x[i] + x[7 - i];
                d[i] = x[i] - x[7 - i];
            end
            X[0] = (s[0] + s[1] + s[2] + s[3]) * 2896;
            X[4] = (s[0] - s[1] - s[2] + s[3]) * 2896;
            X[2] = (s[0] - s[3]) * 3784 + (s[1] - s[2]) * 1567;
            X[6] = (s[0] - s[3]) * 1567 - (s[1] - s[2]) * 3784;
            X[1] = d[0] * 4017 + d[1] * 3406 + d[2] * 2276 + d[3] * 799;
            X[3] = d[0] * 3406 - d[1] * 799 - d[2] * 4017 - d[3] * 2276;
            X[5] = d[0] * 2276 - d[1] * 4017 + d[2] * 799 + d[3] * 3406;
            X[7] = d[0] * 799 - d[1] * 2276 + d[2] * 3406 - d[3] * 4017;
`ifdef AQ_FDCT_ROUND_EN
            for (int j = 0; j < 8; j++) X[j] = (X[j] + 2048) >>> 12;
`endif
            e0[b][pg][0] = X[0]; e1[b][pg][0] = X[4];
            e0[b][pg][1] = X[2]; e1[b][pg][1] = X[6];
            e0[b][pg][2] = X[1]; e1[b][pg][2] = X[7];
            e0[b][pg][3] = X[3]; e1[b][pg][3] = X[5];
        end
    endtask

    task automatic test_reset();
        #1;
        vec++;
        if (DataInRead !== 1'b0 || DataInAddress !== 5'd0 || DataOutEnable !== 1'b0 || DataOutPage !== 3'd0 ||
            DataOutCount !== 2'd0 || Data0Out !== 32'sd0 || Data1Out !== 32'sd0) begin
            bad++;
            $display("FAIL reset_values got rd=%b ad=%0d oe=%b pg=%0d cnt=%0d d0=%0d d1=%0d want all 0",
                     DataInRead, DataInAddress, DataOutEnable, DataOutPage, DataOutCount, Data0Out, Data1Out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (DataInRead !== 1'b0 || DataOutEnable !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got rd=%b oe=%b want 0 0", DataInRead, DataOutEnable);
        end
    endtask

    task automatic test_block(input int pat);
        int  q;
        logic eo;
        load(0, pat);
        bank = 0;
        @(negedge clk);
        DataInEnable = 1'b1;
        @(posedge clk);
        #1 DataInEnable = 1'b0;
        for (int r = 0; r < 72; r++) begin
            @(negedge clk);
            vec++;
            if (DataInRead !== (r < 64 && r % 8 < 4)) begin
                bad++;
                $display("FAIL read_strobe pat=%0d r=%0d got %b want %b", pat, r, DataInRead, r < 64 && r % 8 < 4);
            end else if (DataInRead && DataInAddress !== 5'((r / 8) * 4 + r % 4)) begin
                bad++;
                $display("FAIL read_addr pat=%0d r=%0d got %0d want %0d", pat, r, DataInAddress, (r / 8) * 4 + r % 4);
            end
            q = r - 6;
            eo = q >= 0 && q < 64 && q % 8 < 4;
            vec++;
            if (DataOutEnable !== eo) begin
                bad++;
                $display("FAIL out_enable pat=%0d r=%0d got %b want %b", pat, r, DataOutEnable, eo);
            end else if (eo) begin
                vec++;
                if (DataOutPage !== 3'(q / 8) || DataOutCount !== 2'(q % 8) ||
                    longint'(Data0Out) !== e0[0][q / 8][q % 8] || longint'(Data1Out) !== e1[0][q / 8][q % 8]) begin
                    bad++;
                    $display("FAIL out_pair pat=%0d r=%0d got pg=%0d cnt=%0d (%0d,%0d) want pg=%0d cnt=%0d (%0d,%0d)",
                             pat, r, DataOutPage, DataOutCount, Data0Out, Data1Out,
                             q / 8, q % 8, e0[0][q / 8][q % 8], e1[0][q / 8][q % 8]);
                end
                if (pat < 4 && q < 8) begin
                    vec++;
                    if (longint'(Data0Out) !== hand[pat][2 * q] || longint'(Data1Out) !== hand[pat][2 * q + 1]) begin
                        bad++;
                        $display("FAIL hand_vector pat=%0d k=%0d got (%0d,%0d) want (%0d,%0d)", pat, q,
                                 Data0Out, Data1Out, hand[pat][2 * q], hand[pat][2 * q + 1]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int  qa, qb, rb;
        logic ra, rdb, eo;
        load(0, 4);
        load(1, 5);
        bank = 0;
        @(negedge clk);
        DataInEnable = 1'b1;
        @(posedge clk);
        #1 DataInEnable = 1'b0;
        for (int r = 0; r < 140; r++) begin
            @(negedge clk);
            if (r == 64) begin
                DataInEnable = 1'b1;
                bank = 1;
            end
            if (r == 65) DataInEnable = 1'b0;
            rb = r - 65;
            ra = r < 64 && r % 8 < 4;
            rdb = rb >= 0 && rb < 64 && rb % 8 < 4;
            vec++;
            if (DataInRead !== (ra || rdb)) begin
                bad++;
                $display("FAIL b2b_read r=%0d got %b want %b", r, DataInRead, ra || rdb);
            end else if (DataInRead && DataInAddress !== (ra ? 5'((r / 8) * 4 + r % 4) : 5'((rb / 8) * 4 + rb % 4))) begin
                bad++;
                $display("FAIL b2b_addr r=%0d got %0d", r, DataInAddress);
            end
            qa = r - 6;
            qb = r - 71;
            eo = (qa >= 0 && qa < 64 && qa % 8 < 4) || (qb >= 0 && qb < 64 && qb % 8 < 4);
            vec++;
            if (DataOutEnable !== eo) begin
                bad++;
                $display("FAIL b2b_enable r=%0d got %b want %b", r, DataOutEnable, eo);
            end else if (eo) begin
                int b, q;
                b = (qa >= 0 && qa < 64) ? 0 : 1;
                q = b == 0 ? qa : qb;
                vec++;
                if (DataOutPage !== 3'(q / 8) || DataOutCount !== 2'(q % 8) ||
                    longint'(Data0Out) !== e0[b][q / 8][q % 8] || longint'(Data1Out) !== e1[b][q / 8][q % 8]) begin
                    bad++;
                    $display("FAIL b2b_pair blk=%0d r=%0d got pg=%0d cnt=%0d (%0d,%0d) want pg=%0d cnt=%0d (%0d,%0d)",
                             b, r, DataOutPage, DataOutCount, Data0Out, Data1Out,
                             q / 8, q % 8, e0[b][q / 8][q % 8], e1[b][q / 8][q % 8]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        load(0, 1);
        bank = 0;
        @(negedge clk);
        DataInEnable = 1'b1;
        @(posedge clk);
        #1 DataInEnable = 1'b0;
        repeat (26) @(posedge clk);
        #2;
        vec++;
        if (DataInRead !== 1'b1 || DataInAddress !== 5'b011_10) begin
            bad++;
            $display("FAIL mid_position got rd=%b ad=%0d want 1 14", DataInRead, DataInAddress);
        end
        rst = 1'b0;
        DataInEnable = 1'b1;
        #1;
        vec++;
        if (DataInRead !== 1'b0 || DataInAddress !== 5'd0 || DataOutEnable !== 1'b0 || DataOutPage !== 3'd0 ||
            DataOutCount !== 2'd0 || Data0Out !== 32'sd0 || Data1Out !== 32'sd0) begin
            bad++;
            $display("FAIL mid_reset got rd=%b ad=%0d oe=%b pg=%0d cnt=%0d d0=%0d d1=%0d want all 0",
                     DataInRead, DataInAddress, DataOutEnable, DataOutPage, DataOutCount, Data0Out, Data1Out);
        end
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (DataInRead !== 1'b0 || DataOutEnable !== 1'b0) begin
            bad++;
            $display("FAIL enable_in_reset got rd=%b oe=%b want 0 0", DataInRead, DataOutEnable);
        end
        @(negedge clk);
        DataInEnable = 1'b0;
        rst = 1'b1;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            vec++;
            if (DataInRead !== 1'b0 || DataOutEnable !== 1'b0) begin
                bad++;
                $display("FAIL quiet_after_reset r=%0d got rd=%b oe=%b want 0 0", r, DataInRead, DataOutEnable);
            end
        end
    endtask

    initial begin
        test_reset();
        for (int p = 0; p < 4; p++) test_block(p);
        test_back_to_back();
        test_reset_mid();
        test_block(4);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
